// File: rtl/uart_ctrl.sv
// Bus-master sequencer for the UART register block: programs the divisor, polls STATUS,
// and moves bytes between the UART DATA register and two host-facing byte FIFOs.
module uart_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [15:0] CLK_DIV    = 16'd103,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  tx_data_in,
    input  logic        tx_valid_in,
    output logic        tx_ready_out,
    output logic [7:0]  rx_data_out,
    output logic        rx_valid_out,
    input  logic        rx_ready_in,
    input  logic [15:0] div_value_in,
    input  logic        div_we_in,
    output logic        busy_out,
    output logic [31:0] uart_address_out,
    output logic        uart_sel_out,
    output logic        uart_read_out,
    output logic [3:0]  uart_write_mask_out,
    output logic [31:0] uart_write_value_out,
    input  logic [31:0] uart_read_value_in,
    input  logic        uart_ready_in
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_POLL   = 3'd1;
    localparam logic [2:0] S_RXRD   = 3'd2;
    localparam logic [2:0] S_TXWR   = 3'd3;
    localparam logic [2:0] S_SETDIV = 3'd4;

    logic [2:0]  state;
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [AW:0] tx_cnt, rx_cnt, tx_cnt_nxt;
    logic        tx_full, tx_empty, rx_full;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic        done, status_done, twr_nxt, last_twr;
    logic [15:0] div_latch;
    logic        div_pend;

    assign tx_cnt   = tx_wptr - tx_rptr;
    assign rx_cnt   = rx_wptr - rx_rptr;
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);

    assign tx_ready_out = !tx_full;
    assign rx_valid_out = (rx_cnt != '0);
    assign rx_data_out  = rx_mem[rx_rptr[AW-1:0]];

    assign done        = uart_sel_out && uart_ready_in;
    assign status_done = done && (state == S_POLL);
    assign tx_push     = tx_valid_in && !tx_full;
    assign tx_pop      = done && (state == S_TXWR);
    assign rx_push     = done && (state == S_RXRD) && (uart_read_value_in[31:8] == 24'h0);
    assign rx_pop      = rx_valid_out && rx_ready_in;

    assign tx_cnt_nxt = tx_cnt + PW'(tx_push) - PW'(tx_pop);
    assign twr_nxt    = status_done ? uart_read_value_in[0] : last_twr;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= tx_data_in;
        if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= uart_read_value_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    // A pulse arriving while SETDIV is in flight keeps the flag set, so the newer value follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_pend <= 1'b0;
        end else if (div_we_in) begin
            div_pend <= 1'b1;
        end else if (done && (state == S_SETDIV) && (uart_write_value_out[15:0] == div_latch)) begin
            div_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (div_we_in) div_latch <= div_value_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_twr <= 1'b1;
            busy_out <= 1'b0;
        end else begin
            last_twr <= twr_nxt;
            busy_out <= (tx_cnt_nxt != '0) || !twr_nxt;
        end
    end

    // Each access is one setup cycle with sel low, then sel high until ready completes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= S_INIT;
            uart_sel_out         <= 1'b0;
            uart_read_out        <= 1'b0;
            uart_address_out     <= '0;
            uart_write_mask_out  <= '0;
            uart_write_value_out <= '0;
        end else if (!uart_sel_out) begin
            uart_sel_out <= 1'b1;
            case (state)
                S_INIT: begin
                    uart_address_out     <= BASE_ADDR;
                    uart_read_out        <= 1'b0;
                    uart_write_mask_out  <= 4'b0011;
                    uart_write_value_out <= {16'b0, CLK_DIV};
                end
                S_POLL: begin
                    uart_address_out     <= BASE_ADDR + 32'h4;
                    uart_read_out        <= 1'b1;
                    uart_write_mask_out  <= 4'b0000;
                    uart_write_value_out <= '0;
                end
                S_RXRD: begin
                    uart_address_out     <= BASE_ADDR + 32'h8;
                    uart_read_out        <= 1'b1;
                    uart_write_mask_out  <= 4'b0000;
                    uart_write_value_out <= '0;
                end
                S_TXWR: begin
                    uart_address_out     <= BASE_ADDR + 32'h8;
                    uart_read_out        <= 1'b0;
                    uart_write_mask_out  <= 4'b0001;
                    uart_write_value_out <= {24'b0, tx_mem[tx_rptr[AW-1:0]]};
                end
                default: begin
                    uart_address_out     <= BASE_ADDR;
                    uart_read_out        <= 1'b0;
                    uart_write_mask_out  <= 4'b0011;
                    uart_write_value_out <= {16'b0, div_latch};
                end
            endcase
        end else if (uart_ready_in) begin
            uart_sel_out         <= 1'b0;
            uart_read_out        <= 1'b0;
            uart_address_out     <= '0;
            uart_write_mask_out  <= '0;
            uart_write_value_out <= '0;
            if (state == S_POLL) begin
                if (div_pend)                                state <= S_SETDIV;
                else if (uart_read_value_in[1] && !rx_full)  state <= S_RXRD;
                else if (uart_read_value_in[0] && !tx_empty) state <= S_TXWR;
                else                                         state <= S_POLL;
            end else begin
                state <= S_POLL;
            end
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a register-level UART model (TX busy timer, RX holding
// register, optional loopback of transmitted bytes into RX).
module tb_uart_ctrl;
    localparam int TX_BUSY = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tx_data_in;
    logic        tx_valid_in;
    logic        tx_ready_out;
    logic [7:0]  rx_data_out;
    logic        rx_valid_out;
    logic        rx_ready_in;
    logic [15:0] div_value_in;
    logic        div_we_in;
    logic        busy_out;
    logic [31:0] uart_address_out;
    logic        uart_sel_out;
    logic        uart_read_out;
    logic [3:0]  uart_write_mask_out;
    logic [31:0] uart_write_value_out;
    logic [31:0] uart_read_value_in;
    logic        uart_ready_in;

    uart_ctrl dut (
        .clk(clk), .reset(reset),
        .tx_data_in(tx_data_in), .tx_valid_in(tx_valid_in), .tx_ready_out(tx_ready_out),
        .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out), .rx_ready_in(rx_ready_in),
        .div_value_in(div_value_in), .div_we_in(div_we_in), .busy_out(busy_out),
        .uart_address_out(uart_address_out), .uart_sel_out(uart_sel_out),
        .uart_read_out(uart_read_out), .uart_write_mask_out(uart_write_mask_out),
        .uart_write_value_out(uart_write_value_out), .uart_read_value_in(uart_read_value_in),
        .uart_ready_in(uart_ready_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic [3:0]  mask;
        logic [31:0] val;
    } acc_t;

    acc_t       acc_log[$];
    logic [7:0] tx_log[$];
    logic [7:0] rx_q[$];
    logic [7:0] rx_got[$];

    int          tx_busy = 0;
    logic [7:0]  tx_byte = 8'h0;
    logic        tx_stall = 1'b0;
    logic        loopback = 1'b0;
    logic        rx_junk = 1'b0;
    logic        m_rx_valid = 1'b0;
    logic [7:0]  m_rx_byte = 8'h0;
    logic        m_last_twr = 1'b0;
    logic [15:0] m_div = 16'h0;
    int          div_busy = 0;
    int          n_viol = 0;
    int          n_rxrd = 0;
    logic [31:0] status;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always_comb begin
        status = {30'b0, m_rx_valid, (tx_busy == 0) && !tx_stall};
        uart_read_value_in = 32'h0;
        if (uart_sel_out && uart_address_out == 32'h4) uart_read_value_in = status;
        else if (uart_sel_out && uart_address_out == 32'h8)
            uart_read_value_in = {rx_junk ? 8'hFF : 8'h00, 16'h0, m_rx_byte};
    end

    // UART register model; accesses seen during reset are ignored because the DUT aborts them.
    always @(posedge clk) begin
        if (tx_busy != 0) begin
            tx_busy <= tx_busy - 1;
            if (tx_busy == 1 && loopback) rx_q.push_back(tx_byte);
        end
        if (!m_rx_valid && rx_q.size() != 0) begin
            m_rx_byte  <= rx_q.pop_front();
            m_rx_valid <= 1'b1;
        end
        if (!reset && uart_sel_out && uart_ready_in) begin
            acc_log.push_back({uart_address_out, uart_read_out, uart_write_mask_out, uart_write_value_out});
            if (uart_address_out == 32'h4) begin
                m_last_twr <= status[0];
            end else if (uart_address_out == 32'h8 && uart_read_out) begin
                m_rx_valid <= 1'b0;
                n_rxrd <= n_rxrd + 1;
            end else if (uart_address_out == 32'h8 && uart_write_mask_out != 4'b0) begin
                if (!m_last_twr) n_viol <= n_viol + 1;
                m_last_twr <= 1'b0;
                tx_busy    <= TX_BUSY;
                tx_byte    <= uart_write_value_out[7:0];
                tx_log.push_back(uart_write_value_out[7:0]);
            end else if (uart_address_out == 32'h0 && uart_write_mask_out != 4'b0) begin
                m_div    <= uart_write_value_out[15:0];
                div_busy <= tx_busy;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && rx_valid_out && rx_ready_in) rx_got.push_back(rx_data_out);
    end

    task automatic push_tx(input logic [7:0] b, input int bound, output logic ok);
        ok = 1'b0;
        tx_data_in  = b;
        tx_valid_in = 1'b1;
        for (int i = 0; i < bound && !ok; i++) begin
            ok = tx_ready_out;
            @(negedge clk);
        end
        tx_valid_in = 1'b0;
    endtask

    task automatic wait_log(input int n, input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = (acc_log.size() >= n);
        end
    endtask

    initial begin
        logic ok;
        int   base, txb, rxb, seen;
        acc_t a;
        logic [78:0] snap;
        logic stable;

        reset = 1'b1; tx_data_in = 8'h0; tx_valid_in = 1'b0; rx_ready_in = 1'b1;
        div_value_in = 16'h0; div_we_in = 1'b0; uart_ready_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sel", uart_sel_out, 1'b0);
        check("rst_mask", uart_write_mask_out, 4'h0);
        check("rst_read", uart_read_out, 1'b0);
        check("rst_rx_valid", rx_valid_out, 1'b0);
        check("rst_tx_ready", tx_ready_out, 1'b1);
        check("rst_busy", busy_out, 1'b0);

        // Test 1: INIT divisor write, then STATUS poll
        reset = 1'b0;
        wait_log(2, 50, ok);
        check("init_timeout", ok, 1'b1);
        if (ok) begin
            a = acc_log[0];
            check("init_addr", a.addr, 32'h0);
            check("init_val", a.val, 32'h67);
            check("init_mask", a.mask, 4'b0011);
            a = acc_log[1];
            check("poll_addr", a.addr, 32'h4);
            check("poll_read", a.rd, 1'b1);
        end

        // Test 2: loopback of 0x55, 0xAA
        loopback = 1'b1;
        push_tx(8'h55, 50, ok); check("t2_push0", ok, 1'b1);
        push_tx(8'hAA, 50, ok); check("t2_push1", ok, 1'b1);
        for (int i = 0; i < 2000 && rx_got.size() < 2; i++) @(negedge clk);
        check("t2_rx_cnt", rx_got.size(), 2);
        if (rx_got.size() >= 2) begin
            check("t2_rx0", rx_got[0], 8'h55);
            check("t2_rx1", rx_got[1], 8'hAA);
        end
        check("t2_tx_cnt", tx_log.size(), 2);
        if (tx_log.size() >= 2) check("t2_tx_order", {tx_log[0], tx_log[1]}, 16'h55AA);
        loopback = 1'b0;
        repeat (100) @(negedge clk);
        check("t2_idle_busy", busy_out, 1'b0);

        // Test 3: TX FIFO fill while UART stalled
        tx_stall = 1'b1;
        repeat (10) @(negedge clk);
        txb  = tx_log.size();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            push_tx(8'hC0 + 8'(i), 5, ok);
            if (ok) seen++;
        end
        check("t3_accepted", seen, 8);
        check("t3_full", tx_ready_out, 1'b0);
        check("t3_busy", busy_out, 1'b1);
        check("t3_no_write", tx_log.size(), txb);
        tx_stall = 1'b0;
        push_tx(8'hC8, 3000, ok);
        check("t3_ninth", ok, 1'b1);
        for (int i = 0; i < 3000 && tx_log.size() < txb + 9; i++) @(negedge clk);
        check("t3_tx_cnt", tx_log.size(), txb + 9);
        ok = 1'b1;
        for (int i = 0; i < 9 && txb + i < tx_log.size(); i++)
            if (tx_log[txb + i] != 8'hC0 + 8'(i)) ok = 1'b0;
        check("t3_order", ok, 1'b1);

        // Test 4: RX FIFO full, host stalled
        rx_ready_in = 1'b0;
        rxb  = rx_got.size();
        base = n_rxrd;
        for (int i = 0; i < 9; i++) rx_q.push_back(8'h10 + 8'(i));
        repeat (400) @(negedge clk);
        check("t4_rxrd_cnt", n_rxrd - base, 8);
        check("t4_held_valid", m_rx_valid, 1'b1);
        check("t4_held_byte", m_rx_byte, 8'h18);
        check("t4_rx_valid", rx_valid_out, 1'b1);
        rx_ready_in = 1'b1;
        for (int i = 0; i < 500 && rx_got.size() < rxb + 9; i++) @(negedge clk);
        check("t4_rx_cnt", rx_got.size(), rxb + 9);
        ok = 1'b1;
        for (int i = 0; i < 9 && rxb + i < rx_got.size(); i++)
            if (rx_got[rxb + i] != 8'h10 + 8'(i)) ok = 1'b0;
        check("t4_order", ok, 1'b1);

        // Nonzero upper DATA bits: byte discarded
        rx_junk = 1'b1;
        rxb = rx_got.size();
        rx_q.push_back(8'h5A);
        repeat (100) @(negedge clk);
        check("junk_drop", rx_got.size(), rxb);
        check("junk_read", m_rx_valid, 1'b0);
        rx_junk = 1'b0;

        // Test 5: bus stall during TXWR
        repeat (60) @(negedge clk);
        txb = tx_log.size();
        tx_data_in = 8'h3C; tx_valid_in = 1'b1;
        @(negedge clk);
        tx_valid_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (uart_sel_out && uart_write_mask_out == 4'b0001) ok = 1'b1;
            else @(negedge clk);
        end
        check("t5_found", ok, 1'b1);
        uart_ready_in = 1'b0;
        snap   = {uart_sel_out, uart_read_out, uart_write_mask_out, uart_address_out, uart_write_value_out, 9'h0};
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if ({uart_sel_out, uart_read_out, uart_write_mask_out, uart_address_out, uart_write_value_out, 9'h0} != snap)
                stable = 1'b0;
        end
        check("t5_stable", stable, 1'b1);
        check("t5_val", uart_write_value_out, 32'h3C);
        check("t5_no_write", tx_log.size(), txb);
        uart_ready_in = 1'b1;
        @(negedge clk);
        check("t5_one_write", tx_log.size(), txb + 1);
        repeat (200) @(negedge clk);
        check("t5_no_dup", tx_log.size(), txb + 1);

        // Test 6: divisor change during active frame, then reset mid-RXRD
        push_tx(8'h81, 50, ok);
        for (int i = 0; i < 200 && tx_busy == 0; i++) @(negedge clk);
        base = acc_log.size();
        div_value_in = 16'h0010; div_we_in = 1'b1;
        @(negedge clk);
        div_we_in = 1'b0;
        ok = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            for (int j = base; j < acc_log.size(); j++)
                if (!ok && acc_log[j].addr == 32'h0 && acc_log[j].mask == 4'b0011) begin
                    ok = 1'b1; seen = j;
                end
        end
        check("t6_setdiv", ok, 1'b1);
        if (ok) begin
            check("t6_setdiv_val", acc_log[seen].val, 32'h10);
            check("t6_after_poll", acc_log[seen - 1].addr, 32'h4);
        end
        check("t6_m_div", m_div, 16'h10);
        check("t6_during_tx", div_busy != 0, 1'b1);

        repeat (100) @(negedge clk);
        rxb = rx_got.size();
        rx_q.push_back(8'h77);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (uart_sel_out && uart_read_out && uart_address_out == 32'h8) ok = 1'b1;
            else @(negedge clk);
        end
        check("t6_rxrd_found", ok, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_sel", uart_sel_out, 1'b0);
        check("t6_rst_rx_valid", rx_valid_out, 1'b0);
        check("t6_rst_tx_ready", tx_ready_out, 1'b1);
        check("t6_rst_busy", busy_out, 1'b0);
        check("t6_no_push", rx_got.size(), rxb);
        base = acc_log.size();
        reset = 1'b0;
        wait_log(base + 1, 50, ok);
        check("t6_reinit_to", ok, 1'b1);
        if (ok) begin
            a = acc_log[base];
            check("t6_reinit", {a.addr, a.mask, a.val}, {32'h0, 4'b0011, 32'h67});
        end

        check("no_tx_violation", n_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
